// File: rtl/seq_alu.sv
// Registered, parametrised ALU with valid/ready input, accumulator feedback and
// an optional shift-add multiplier built only when SEQ_ALU_MUL_EN is defined.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             use_acc,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             c_out,
  output logic             zero,
  output logic             illegal,
  output logic             out_valid
);

  logic [WIDTH-1:0] out_q;
  logic             c_out_q;
  logic             zero_q;
  logic             illegal_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] acc_q;

  logic [WIDTH-1:0] xe;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_lo;
  logic             res_c;
  logic             res_ill;
  logic             fire;

  always_comb begin
    xe      = use_acc ? acc_q : x;
    b       = '0;
    cin     = 1'b0;
    sum     = '0;
    res_lo  = '0;
    res_c   = 1'b0;
    res_ill = 1'b0;
    if (!select[3]) begin
      case (select[2:1])
        2'd0:    b = '0;
        2'd1:    b = y;
        2'd2:    b = ~y;
        default: b = '1;
      endcase
      cin    = select[0];
      sum    = {1'b0, xe} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      res_lo = sum[WIDTH-1:0];
      res_c  = sum[WIDTH];
    end else begin
      case (select[2:0])
        3'd0:    res_lo = xe & y;
        3'd1:    res_lo = xe | y;
        3'd2:    res_lo = xe ^ y;
        3'd3:    res_lo = ~xe;
`ifdef SEQ_ALU_MUL_EN
        3'd4:    res_ill = 1'b0;   // multiply handled by the MUL state
`endif
        default: res_ill = 1'b1;
      endcase
    end
  end

  assign fire = in_valid && in_ready;

`ifdef SEQ_ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t state_q, state_d;

  logic [2*WIDTH-1:0] mcand_q, prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   out_hi_q;
  logic [CW-1:0]      cnt_q;
  logic               is_mul;
  logic               mul_last;

  assign is_mul   = (select == 4'hC);
  assign mul_last = (state_q == S_MUL) && (cnt_q == CW'(1));
  assign prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fire && is_mul) state_d = S_MUL;
      default: if (mul_last)       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (fire && is_mul) begin
      mcand_q  <= {{WIDTH{1'b0}}, xe};
      mplier_q <= y;
      prod_q   <= '0;
      cnt_q    <= CW'(WIDTH);
    end else if (state_q == S_MUL) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      prod_q   <= prod_d;
      cnt_q    <= cnt_q - CW'(1);
    end
  end
`else
  localparam logic is_mul = 1'b0;
  localparam logic mul_last = 1'b0;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   out_hi_q;

  assign in_ready = 1'b1;
  assign prod_d   = '0;
  assign out_hi_q = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      c_out_q     <= 1'b0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (fire && !is_mul) begin
        out_q       <= res_lo;
        c_out_q     <= res_c;
        zero_q      <= (res_lo == '0);
        illegal_q   <= res_ill;
        out_valid_q <= 1'b1;
        if (!res_ill) acc_q <= res_lo;
      end else if (mul_last) begin
        out_q       <= prod_d[WIDTH-1:0];
        c_out_q     <= (prod_d[2*WIDTH-1:WIDTH] != '0);
        zero_q      <= (prod_d == '0);
        illegal_q   <= 1'b0;
        out_valid_q <= 1'b1;
        acc_q       <= prod_d[WIDTH-1:0];
      end
    end
  end

`ifdef SEQ_ALU_MUL_EN
  always_ff @(posedge clk) begin
    if (reset)                  out_hi_q <= '0;
    else if (fire && !is_mul)   out_hi_q <= '0;
    else if (mul_last)          out_hi_q <= prod_d[2*WIDTH-1:WIDTH];
  end
`endif

  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign c_out     = c_out_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Registered, parametrised successor to the 4-bit combinational ALU. It keeps the same 12 select codes and the same carry semantics, and adds four things: a WIDTH parameter, a valid/ready input handshake, an accumulator that can feed back as the x operand, and a multi-cycle shift-add multiplier. It sits between the lab datapath register file and the result bus, producing one registered result per accepted operation.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation request; accepted on a rising edge where in_valid && in_ready
- in_ready  out  1  high when the block can accept a request (FSM in IDLE)
- select  in  4  opcode (see Operation)
- x, y  in  WIDTH  operands
- use_acc  in  1  when 1, the accumulator replaces x as the x operand
- out  out  WIDTH  result (low half for multiply)
- out_hi  out  WIDTH  high half of product; 0 for every other opcode
- c_out  out  1  carry-out / multiply overflow
- zero  out  1  high when {out_hi,out} == 0
- illegal  out  1  opcode unsupported
- out_valid  out  1  one-cycle pulse marking a new result

## Operation
- Effective operand: xe = use_acc ? acc : x, sampled at the accept edge.
- Arithmetic: {c_out,out} = xe + b + cin, computed WIDTH+1 bits wide. b and cin per opcode:
  - 0: b=0, cin=0
  - 1: b=0, cin=1
  - 2: b=y, cin=0
  - 3: b=y, cin=1
  - 4: b=~y, cin=0
  - 5: b=~y, cin=1
  - 6: b=all-ones, cin=0
  - 7: b=all-ones, cin=1 (out=xe, c_out=1)
- Logic (c_out=0):
  - 8: xe & y
  - 9: xe | y
  - A: xe ^ y
  - B: ~xe
- C: multiply, unsigned xe*y, 2·WIDTH-bit product. c_out = (out_hi != 0).
- D, E, F: illegal. out=0, out_hi=0, c_out=0, zero=1, illegal=1.
- Accumulator acc (WIDTH bits):
  - Loaded with out on every out_valid pulse except illegal results.
  - No software clear; an opcode 8 with y=0 clears it.
- FSM:
  - IDLE: in_ready=1. Accepting a non-C op produces the result registered on the same edge; state stays IDLE. Accepting C loads multiplicand, multiplier and a partial sum of 0, sets count=WIDTH, moves to MUL.
  - MUL: in_ready=0. One multiplier bit per cycle (add-if-LSB, shift). When count reaches 0, result registers load, out_valid pulses, state returns to IDLE.
- in_valid while in_ready=0 is ignored; the requester must hold it.

## Timing
- Reset values: out=0, out_hi=0, c_out=0, zero=1, illegal=0, out_valid=0, in_ready=1, acc=0, FSM=IDLE.
- Non-multiply latency: accept at edge N; outputs valid and out_valid=1 after edge N. Throughput is one op per cycle.
- Multiply latency: accept at edge N; in_ready=0 after edges N..N+WIDTH−1; result and out_valid after edge N+WIDTH; in_ready=1 again after edge N+WIDTH.
- Outputs hold their last result between pulses; out_valid is high for exactly one cycle per result.
- Reset mid-multiply: the operation is aborted, all outputs take their reset values at that edge, and no out_valid is produced.
- Back-to-back use_acc: an op accepted the cycle after a result uses that updated acc (acc is a register written on the result edge).

## Configuration
- SEQ_ALU_MUL_EN:
  - Defined: multiplier and the MUL state are built; opcode C behaves as above.
  - Undefined: no multiplier logic. Opcode C is illegal (single-cycle, illegal=1), out_hi is tied to 0, in_ready is constantly 1.

## Test plan
- Reset held 2 cycles -> out=0, out_hi=0, zero=1, out_valid=0, in_ready=1, acc=0.
- WIDTH=4, select=2, x=9, y=8 -> next cycle out=1, c_out=1, out_valid=1, zero=0; select=5, x=3, y=5 -> out=E, c_out=0.
- Sweep all 16×16 x,y for opcodes 0–B -> every result matches the WIDTH+1-bit reference model above, one result per cycle.
- SEQ_ALU_MUL_EN, select=C, x=D, y=B, with in_valid held high through the busy period:
  - Required: in_ready low for 4 cycles; after edge N+4, out=F, out_hi=8, c_out=1, out_valid=1.
  - Required: exactly one result is produced while busy, i.e. the held request is not double-counted.
- select=1, x=7 -> out=8, acc=8; then use_acc=1, select=2, y=3 -> out=B, acc=B; then select=E -> illegal=1, out=0, acc stays B.
- Start multiply, assert reset 2 cycles after accept -> no out_valid pulse, all outputs at reset values, in_ready=1 on the next cycle.
